// File: rtl/ram_bank_pkg.sv
// Shared types and helpers for the ram_bank family of storage blocks.
package ram_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } ram_state_t;

  // Callers zero-extend their word to this width; zero-extension does not change parity.
  localparam int PAR_MAX_W = 1024;

  function automatic logic even_par(input logic [PAR_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_word.sv
// One load-enabled storage word with asynchronous active-low reset.
module ram_word #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ram_bank.sv
// Addressable bank of DEPTH load registers with a sequential clear engine.
// Optional per-word even parity is enabled by defining RAM_PARITY_EN.
//
//   state | meaning
//   IDLE  | normal operation: combinational read, load writes mem[address]
//   CLEAR | zeroing mem[ptr] one word per edge; load and clr_req ignored
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           in,
  input  logic                       load,
  input  logic [$clog2(DEPTH)-1:0]   address,
  input  logic                       clr_req,
  input  logic                       par_inj,
  output logic [WIDTH-1:0]           out,
  output logic                       busy,
  output logic                       perr
);

  localparam int AW = $clog2(DEPTH);
`ifdef RAM_PARITY_EN
  localparam int WW = WIDTH + 1;
`else
  localparam int WW = WIDTH;
`endif

  ram_state_t      state;
  logic [AW-1:0]   ptr;
  logic [WW-1:0]   wr_data;
  logic [WW-1:0]   rd_word;
  logic [WW-1:0]   q [DEPTH];
  logic [DEPTH-1:0] we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == AW'(DEPTH - 1)) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_data = '0;
    if (state == IDLE) begin
`ifdef RAM_PARITY_EN
      wr_data = {even_par(PAR_MAX_W'(in)) ^ par_inj, in};
`else
      wr_data = in;
`endif
    end
  end

`ifndef RAM_PARITY_EN
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    // Clear has priority: a clr_req edge in IDLE must not also load.
    assign we[i] = (state == CLEAR && ptr == AW'(i)) ||
                   (state == IDLE && !clr_req && load && address == AW'(i));

    ram_word #(.W(WW)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (we[i]),
      .d     (wr_data),
      .q     (q[i])
    );
  end

  assign rd_word = q[address];
  assign out     = rd_word[WIDTH-1:0];

`ifdef RAM_PARITY_EN
  assign perr = even_par(PAR_MAX_W'(rd_word[WIDTH-1:0])) ^ rd_word[WIDTH];
`else
  assign perr = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bank.sv
// Directed self-checking bench for ram_bank (WIDTH=16, DEPTH=8).
module tb_ram_bank;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             load = 1'b0;
  logic [AW-1:0]    address = '0;
  logic             clr_req = 1'b0;
  logic             par_inj = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             perr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (din),
    .load    (load),
    .address (address),
    .clr_req (clr_req),
    .par_inj (par_inj),
    .out     (dout),
    .busy    (busy),
    .perr    (perr)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state, all addresses
    #12;
    for (int a = 0; a < DEPTH; a++) begin
      address = AW'(a);
      #1;
      check("rst_out", dout, 16'h0000);
      check("rst_busy", {15'b0, busy}, 16'h0000);
      check("rst_perr", {15'b0, perr}, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic writes, old value visible before the edge
    address = 3'd3; din = 16'hA5A5; load = 1'b1;
    #1;
    check("pre_edge_addr3", dout, 16'h0000);
    tick();
    check("post_edge_addr3", dout, 16'hA5A5);
    address = 3'd7; din = 16'h1234;
    tick();
    load = 1'b0;
    check("addr7", dout, 16'h1234);
    address = 3'd3;
    #1;
    check("addr3_readback", dout, 16'hA5A5);

    // Fill the bank
    for (int i = 0; i < DEPTH; i++) begin
      address = AW'(i); din = 16'h1000 + 16'(i); load = 1'b1;
      tick();
    end
    load = 1'b0;

    // Clear with a simultaneous load to addr 0: load must be ignored
    clr_req = 1'b1; load = 1'b1; address = 3'd0; din = 16'hFFFF;
    tick();
    clr_req = 1'b0; load = 1'b0;
    check("clr_busy_rise", {15'b0, busy}, 16'h0001);
    check("clr_load_ignored", dout, 16'h1000);
    address = 3'd5;
    #1;
    check("clr_addr5_start", dout, 16'h1005);
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 4) begin
        address = 3'd1; din = 16'hBEEF; load = 1'b1;
      end
      tick();
      load = 1'b0; address = 3'd5;
      #1;
      check($sformatf("clr_busy_k%0d", k), {15'b0, busy}, (k != DEPTH - 1) ? 16'h0001 : 16'h0000);
      check($sformatf("clr_addr5_k%0d", k), dout, (k >= 5) ? 16'h0000 : 16'h1005);
    end
    address = 3'd1;
    #1;
    check("load_during_busy", dout, 16'h0000);

    // First write after busy falls is accepted
    address = 3'd2; din = 16'h5555; load = 1'b1;
    tick();
    load = 1'b0;
    check("post_clear_write", dout, 16'h5555);
    for (int a = 0; a < DEPTH; a++) begin
      address = AW'(a);
      #1;
      check($sformatf("cleared_addr%0d", a), dout, (a == 2) ? 16'h5555 : 16'h0000);
    end

    // Reset during the third clear cycle
    address = 3'd6; din = 16'h6666; load = 1'b1;
    tick();
    load = 1'b0;
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    tick();
    check("midclr_busy", {15'b0, busy}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("rst_midclr_busy", {15'b0, busy}, 16'h0000);
    for (int a = 0; a < DEPTH; a++) begin
      address = AW'(a);
      #1;
      check($sformatf("rst_midclr_addr%0d", a), dout, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    address = 3'd4; din = 16'h4444; load = 1'b1;
    tick();
    load = 1'b0;
    check("post_rst_write", dout, 16'h4444);
    check("post_rst_busy", {15'b0, busy}, 16'h0000);

    // Parity injection
    address = 3'd2; din = 16'h0001; par_inj = 1'b1; load = 1'b1;
    tick();
    load = 1'b0; par_inj = 1'b0;
    check("par_data", dout, 16'h0001);
`ifdef RAM_PARITY_EN
    check("perr_inj_addr2", {15'b0, perr}, 16'h0001);
`else
    check("perr_off_addr2", {15'b0, perr}, 16'h0000);
`endif
    address = 3'd3;
    #1;
    check("perr_addr3", {15'b0, perr}, 16'h0000);
    address = 3'd2; din = 16'h0001; load = 1'b1;
    tick();
    load = 1'b0;
    check("perr_rewrite", {15'b0, perr}, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
